// File: rtl/array_access_arbiter_pkg.sv
// Shared types and index helpers for the array access arbiter.
package array_access_arbiter_pkg;

    // Sequencer states:
    //   IDLE   | pick a winner among pending requests and capture its command
    //   ACCESS | execute the captured command against the array
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // (base + off) mod n, assuming base < n and off < n.
    function automatic int unsigned rr_wrap(input int unsigned base,
                                            input int unsigned off,
                                            input int unsigned n);
        int unsigned s;
        s = base + off;
        return (s >= n) ? (s - n) : s;
    endfunction

    // Round-robin pointer that follows winner k: (k + 1) mod n.
    function automatic int unsigned rr_next(input int unsigned k,
                                            input int unsigned n);
        return (k + 32'd1 >= n) ? 32'd0 : (k + 32'd1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick
    import array_access_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          req [0:N-1],
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);

    // Scan from the farthest offset back to ptr so the nearest hit wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req[IW'(rr_wrap(32'(ptr), unsigned'(j), unsigned'(N)))]) begin
                any = 1'b1;
                idx = IW'(rr_wrap(32'(ptr), unsigned'(j), unsigned'(N)));
            end
        end
    end

endmodule

// File: rtl/array_access_arbiter.sv
// Round-robin arbiter and two-state sequencer sharing one word array among N requesters.
module array_access_arbiter
    import array_access_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 8,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int IW   = $clog2(N)
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          req   [0:N-1],
    input  logic          we    [0:N-1],
    input  logic [AW-1:0] addr  [0:N-1],
    input  logic [W-1:0]  wdata [0:N-1],
    output logic          gnt   [0:N-1],
    output logic          rvalid,
    output logic [W-1:0]  rdata,
    output logic [IW-1:0] rid,
    output logic          busy
);

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [W-1:0]  wdata;
        logic [IW-1:0] id;
    } cmd_t;

    logic [W-1:0]  mem [0:DEPTH-1];

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    cmd_t          cmd_q, cmd_d;
    logic          rvalid_q, rvalid_d;
    logic [W-1:0]  rdata_q, rdata_d;
    logic [IW-1:0] rid_q, rid_d;

    logic          mem_we;
    logic          in_range;
    logic          pick_any;
    logic [IW-1:0] pick_idx;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_rr_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Addresses at or beyond DEPTH never touch the array.
    assign in_range = (32'(cmd_q.addr) < 32'(DEPTH));

    assign busy   = (state_q == ACCESS);
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign rid    = rid_q;

    // Next-state, grant and capture logic; gnt is held low throughout reset.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cmd_d    = cmd_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        rid_d    = rid_q;
        mem_we   = 1'b0;
        for (int i = 0; i < N; i++) begin
            gnt[i] = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (rst_n && pick_any) begin
                    gnt[pick_idx] = 1'b1;
                    cmd_d.we      = we[pick_idx];
                    cmd_d.addr    = addr[pick_idx];
                    cmd_d.wdata   = wdata[pick_idx];
                    cmd_d.id      = pick_idx;
                    ptr_d         = IW'(rr_next(32'(pick_idx), unsigned'(N)));
                    state_d       = ACCESS;
                end
            end
            ACCESS: begin
                state_d = IDLE;
                if (cmd_q.we) begin
                    mem_we = in_range;
                end else begin
                    rvalid_d = 1'b1;
                    rdata_d  = in_range ? mem[cmd_q.addr] : '0;
                    rid_d    = cmd_q.id;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer, pointer, captured command and read-port registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            cmd_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rid_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cmd_q    <= cmd_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rid_q    <= rid_d;
        end
    end

    // Shared array; a write lands at the end of its ACCESS cycle.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[cmd_q.addr] <= cmd_q.wdata;
        end
    end

endmodule

// File: tb/tb_array_access_arbiter.sv
// Directed bench: an 8-word and a 6-word instance share all requester stimulus.
module tb_array_access_arbiter;

    localparam int N = 4;

    logic       clock = 1'b0;
    logic       rst_n;
    logic       req   [0:N-1];
    logic       we    [0:N-1];
    logic [2:0] addr  [0:N-1];
    logic [7:0] wdata [0:N-1];

    logic       gnt8 [0:N-1];
    logic       gnt6 [0:N-1];
    logic       rvalid8, rvalid6;
    logic [7:0] rdata8, rdata6;
    logic [1:0] rid8, rid6;
    logic       busy8, busy6;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    array_access_arbiter #(.N(N), .DEPTH(8), .W(8)) dut8 (
        .clock (clock), .rst_n (rst_n),
        .req (req), .we (we), .addr (addr), .wdata (wdata),
        .gnt (gnt8), .rvalid (rvalid8), .rdata (rdata8), .rid (rid8), .busy (busy8)
    );

    array_access_arbiter #(.N(N), .DEPTH(6), .W(8)) dut6 (
        .clock (clock), .rst_n (rst_n),
        .req (req), .we (we), .addr (addr), .wdata (wdata),
        .gnt (gnt6), .rvalid (rvalid6), .rdata (rdata6), .rid (rid6), .busy (busy6)
    );

    // -1: no grant, k: only gnt[k] high, -2: more than one grant.
    function automatic int gnt_code(input logic g [0:N-1]);
        int code = -1;
        for (int i = 0; i < N; i++) begin
            if (g[i] !== 1'b0) code = (code == -1) ? i : -2;
        end
        return code;
    endfunction

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = 3'd0; wdata[i] = 8'd0;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Raise one request, wait (bounded) for its grant, drop req the cycle after.
    task automatic issue(input int p, input logic w, input logic [2:0] a,
                         input logic [7:0] d, output int gcyc);
        req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
        gcyc = -1;
        for (int c = 0; c < 2 * N + 2; c++) begin
            @(negedge clock);
            if (gnt8[p] === 1'b1) begin
                gcyc = cyc;
                break;
            end
            tick();
        end
        tick();
        req[p] = 1'b0;
    endtask

    task automatic do_write(input int p, input logic [2:0] a, input logic [7:0] d,
                            output int gcyc, output logic busy_acc, output logic rv_after);
        issue(p, 1'b1, a, d, gcyc);
        busy_acc = busy8;
        tick();
        rv_after = rvalid8 | rvalid6;
    endtask

    task automatic do_read(input int p, input logic [2:0] a, output int gcyc,
                           output logic busy_acc, output logic rv8, output logic [7:0] rd8,
                           output logic [1:0] ri8, output logic rv6, output logic [7:0] rd6,
                           output logic rv_next);
        issue(p, 1'b0, a, 8'h00, gcyc);
        busy_acc = busy8;
        tick();
        rv8 = rvalid8; rd8 = rdata8; ri8 = rid8; rv6 = rvalid6; rd6 = rdata6;
        tick();
        rv_next = rvalid8;
    endtask

    task automatic test_reset();
        int g, t0;
        logic b, rv, rv6, rvn;
        logic [7:0] rd, rd6;
        logic [1:0] ri;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) begin
                req[i]   = 1'($urandom_range(0, 1));
                we[i]    = 1'($urandom_range(0, 1));
                addr[i]  = 3'($urandom_range(0, 7));
                wdata[i] = 8'($urandom_range(0, 255));
            end
            req[k] = 1'b1;
            @(negedge clock);
            checks++;
            if (gnt_code(gnt8) !== -1) begin
                errors++; $display("FAIL reset_gnt8: code %0d, required -1", gnt_code(gnt8));
            end
            checks++;
            if (gnt_code(gnt6) !== -1) begin
                errors++; $display("FAIL reset_gnt6: code %0d, required -1", gnt_code(gnt6));
            end
            checks++;
            if ({rvalid8, rdata8, rid8, busy8} !== 12'h000) begin
                errors++; $display("FAIL reset_out8: %h, required 000", {rvalid8, rdata8, rid8, busy8});
            end
            checks++;
            if ({rvalid6, rdata6, rid6, busy6} !== 12'h000) begin
                errors++; $display("FAIL reset_out6: %h, required 000", {rvalid6, rdata6, rid6, busy6});
            end
            tick();
        end
        clear_reqs();
        #2 rst_n = 1'b1;
        tick();
        for (int a = 0; a < 8; a++) begin
            t0 = cyc;
            do_read(a % N, 3'(a), g, b, rv, rd, ri, rv6, rd6, rvn);
            checks++;
            if (g !== t0 || b !== 1'b1) begin
                errors++; $display("FAIL post_reset_gnt a=%0d: gnt cycle %0d busy %b, required %0d busy 1", a, g, b, t0);
            end
            checks++;
            if (rv !== 1'b1 || rd !== 8'h00 || ri !== 2'(a % N)) begin
                errors++; $display("FAIL post_reset_read a=%0d: rvalid %b rdata %h rid %0d, required 1 00 %0d", a, rv, rd, ri, a % N);
            end
            checks++;
            if (rv6 !== 1'b1 || rd6 !== 8'h00 || rvn !== 1'b0) begin
                errors++; $display("FAIL post_reset_read6 a=%0d: rvalid6 %b rdata6 %h next rvalid %b, required 1 00 0", a, rv6, rd6, rvn);
            end
        end
    endtask

    task automatic test_single_requester();
        int t0, gw, gr;
        logic b, rva, rv, rv6, rvn;
        logic [7:0] rd, rd6;
        logic [1:0] ri;
        t0 = cyc;
        do_write(2, 3'd3, 8'hA5, gw, b, rva);
        checks++;
        if (gw !== t0 || b !== 1'b1 || rva !== 1'b0) begin
            errors++; $display("FAIL single_write: gnt cycle %0d busy %b rvalid %b, required %0d 1 0", gw, b, rva, t0);
        end
        do_read(2, 3'd3, gr, b, rv, rd, ri, rv6, rd6, rvn);
        checks++;
        if (gr !== gw + 2) begin
            errors++; $display("FAIL single_gap: read gnt cycle %0d, required %0d", gr, gw + 2);
        end
        checks++;
        if (rv !== 1'b1 || rd !== 8'hA5 || ri !== 2'd2 || rd6 !== 8'hA5) begin
            errors++; $display("FAIL single_read: rvalid %b rdata %h rid %0d rdata6 %h, required 1 a5 2 a5", rv, rd, ri, rd6);
        end
        checks++;
        if (rvn !== 1'b0) begin
            errors++; $display("FAIL single_rvalid_pulse: rvalid %b one cycle later, required 0", rvn);
        end
    endtask

    task automatic test_fairness();
        int g, obs;
        logic b, rv, rv6, rvn;
        logic [7:0] rd, rd6;
        logic [1:0] ri;
        int exp1 [0:11] = '{0, -1, 1, -1, 2, -1, 3, -1, 0, -1, 1, -1};
        int exp2 [0:7]  = '{0, -1, 2, -1, 3, -1, 0, -1};
        do_read(3, 3'd0, g, b, rv, rd, ri, rv6, rd6, rvn);
        for (int i = 0; i < N; i++) begin
            req[i] = 1'b1; we[i] = 1'b0; addr[i] = 3'(i);
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            obs = gnt_code(gnt8);
            checks++;
            if (obs !== exp1[c]) begin
                errors++; $display("FAIL fair_all c=%0d: grant %0d, required %0d", c, obs, exp1[c]);
            end
            if (c >= 2 && exp1[c - 2] >= 0) begin
                checks++;
                if (rvalid8 !== 1'b1 || rid8 !== 2'(exp1[c - 2])) begin
                    errors++; $display("FAIL fair_rid c=%0d: rvalid %b rid %0d, required 1 %0d", c, rvalid8, rid8, exp1[c - 2]);
                end
            end
            tick();
        end
        clear_reqs();
        do_read(3, 3'd0, g, b, rv, rd, ri, rv6, rd6, rvn);
        for (int i = 0; i < N; i++) begin
            req[i] = 1'b1; we[i] = 1'b0; addr[i] = 3'(i);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            obs = gnt_code(gnt8);
            checks++;
            if (obs !== exp2[c]) begin
                errors++; $display("FAIL fair_drop c=%0d: grant %0d, required %0d", c, obs, exp2[c]);
            end
            tick();
            if (c == 0) req[1] = 1'b0;
        end
        clear_reqs();
    endtask

    task automatic test_conflict();
        int g;
        logic b, rv, rv6, rvn;
        logic [7:0] rd, rd6;
        logic [1:0] ri;
        do_read(3, 3'd0, g, b, rv, rd, ri, rv6, rd6, rvn);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 3'd5; wdata[0] = 8'h11;
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 3'd5; wdata[1] = 8'h22;
        @(negedge clock);
        checks++;
        if (gnt_code(gnt8) !== 0) begin
            errors++; $display("FAIL conflict_first: grant %0d, required 0", gnt_code(gnt8));
        end
        tick();
        req[0] = 1'b0;
        tick();
        @(negedge clock);
        checks++;
        if (gnt_code(gnt8) !== 1) begin
            errors++; $display("FAIL conflict_second: grant %0d, required 1", gnt_code(gnt8));
        end
        tick();
        req[1] = 1'b0;
        tick();
        do_read(2, 3'd5, g, b, rv, rd, ri, rv6, rd6, rvn);
        checks++;
        if (rv !== 1'b1 || rd !== 8'h22 || rd6 !== 8'h22) begin
            errors++; $display("FAIL conflict_read: rvalid %b rdata %h rdata6 %h, required 1 22 22", rv, rd, rd6);
        end
    endtask

    task automatic test_out_of_range();
        int g;
        logic b, rva, rv, rv6, rvn;
        logic [7:0] rd, rd6;
        logic [1:0] ri;
        logic [7:0] exp6 [0:5] = '{8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h22};
        do_write(0, 3'd7, 8'hFF, g, b, rva);
        checks++;
        if (b !== 1'b1 || rva !== 1'b0) begin
            errors++; $display("FAIL oor_write: busy %b rvalid %b, required 1 0", b, rva);
        end
        do_read(1, 3'd7, g, b, rv, rd, ri, rv6, rd6, rvn);
        checks++;
        if (rv6 !== 1'b1 || rd6 !== 8'h00 || rid6 !== 2'd1) begin
            errors++; $display("FAIL oor_read6: rvalid %b rdata %h rid %0d, required 1 00 1", rv6, rd6, rid6);
        end
        checks++;
        if (rv !== 1'b1 || rd !== 8'hFF) begin
            errors++; $display("FAIL oor_read8: rvalid %b rdata %h, required 1 ff", rv, rd);
        end
        for (int a = 0; a < 6; a++) begin
            do_read(a % N, 3'(a), g, b, rv, rd, ri, rv6, rd6, rvn);
            checks++;
            if (rv6 !== 1'b1 || rd6 !== exp6[a]) begin
                errors++; $display("FAIL oor_mem6 a=%0d: rvalid %b rdata %h, required 1 %h", a, rv6, rd6, exp6[a]);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        int g;
        logic b, rv, rv6, rvn, stray;
        logic [7:0] rd, rd6;
        logic [1:0] ri;
        issue(0, 1'b1, 3'd1, 8'h3C, g);
        checks++;
        if (busy8 !== 1'b1) begin
            errors++; $display("FAIL midrst_in_access: busy %b, required 1", busy8);
        end
        #2 rst_n = 1'b0;
        @(negedge clock);
        checks++;
        if (busy8 !== 1'b0 || rvalid8 !== 1'b0 || gnt_code(gnt8) !== -1) begin
            errors++; $display("FAIL midrst_abort: busy %b rvalid %b grant %0d, required 0 0 -1", busy8, rvalid8, gnt_code(gnt8));
        end
        tick();
        #2 rst_n = 1'b1;
        stray = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (rvalid8 !== 1'b0 || rvalid6 !== 1'b0) stray = 1'b1;
        end
        tick();
        checks++;
        if (stray !== 1'b0) begin
            errors++; $display("FAIL midrst_stray: stray rvalid %b, required 0", stray);
        end
        do_read(0, 3'd1, g, b, rv, rd, ri, rv6, rd6, rvn);
        checks++;
        if (rv !== 1'b1 || rd !== 8'h00 || rd6 !== 8'h00) begin
            errors++; $display("FAIL midrst_read: rvalid %b rdata %h rdata6 %h, required 1 00 00", rv, rd, rd6);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_reqs();
        tick();
        test_reset();
        test_single_requester();
        test_fairness();
        test_conflict();
        test_out_of_range();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d errors so far", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
